// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared state encodings, Booth op codes, iteration defaults and
//               the radix-4 Booth decode helper for the multdiv controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    localparam int DEF_MULT_ITERS = 16;
    localparam int DEF_DIV_ITERS  = 32;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] BOOTH_NONE   = 3'b000;
    localparam logic [2:0] BOOTH_ADD_A  = 3'b001;
    localparam logic [2:0] BOOTH_ADD_2A = 3'b010;
    localparam logic [2:0] BOOTH_SUB_A  = 3'b101;
    localparam logic [2:0] BOOTH_SUB_2A = 3'b110;

    // bits = {q[1], q[0], q[-1]}
    function automatic logic [2:0] booth_decode(input logic [2:0] bits);
        logic [2:0] op;
        case (bits)
            3'b001, 3'b010: op = BOOTH_ADD_A;
            3'b011:         op = BOOTH_ADD_2A;
            3'b100:         op = BOOTH_SUB_2A;
            3'b101, 3'b110: op = BOOTH_SUB_A;
            default:        op = BOOTH_NONE;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_iter_counter.sv
// ============================================================================
// Module      : iter_counter
// Description : Iteration counter with sync clear, enable, saturation and a
//               terminal-count compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_counter #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] count,
    output logic          at_term
);

    logic [CW-1:0] r_count;

    // The all-ones guard keeps the counter from ever wrapping, even if enable
    // were held past the end of an operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count   = r_count;
    assign at_term = (r_count == term);

endmodule

`default_nettype wire

// File: rtl/multdiv_control.sv
// ============================================================================
// Module      : multdiv_control
// Description : Sequencer for the multiply/divide datapath: radix-4 Booth
//               multiply, non-restoring divide, ready pulse and exception.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_control
    import multdiv_pkg::*;
#(
    parameter int WIDTH      = DEF_DIV_ITERS,
    parameter int MULT_ITERS = DEF_MULT_ITERS,
    parameter int DIV_ITERS  = WIDTH,
    parameter int CW         = $clog2(DIV_ITERS) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ctrl_MULT,
    input  logic          ctrl_DIV,
    input  logic          divisor_zero,
    input  logic [2:0]    mult_bits,
    input  logic          rem_sign,
    input  logic          mult_ovf,
    output logic          dp_load,
    output logic          dp_step,
    output logic [2:0]    booth_op,
    output logic          div_sub,
    output logic          div_fix,
    output logic          busy,
    output logic          data_resultRDY,
    output logic          data_exception,
    output logic [CW-1:0] iter_count
);

    localparam logic [CW-1:0] C_MULT_LAST = CW'(MULT_ITERS - 1);
    localparam logic [CW-1:0] C_DIV_LAST  = CW'(DIV_ITERS - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic          r_op_div;
    logic          r_dbz;
    logic          w_start;
    logic          w_cnt_en;
    logic [CW-1:0] w_term;
    logic          w_last;

    assign w_start  = ctrl_MULT | ctrl_DIV;
    assign w_cnt_en = (r_state == S_MULT) || (r_state == S_DIV);
    assign w_term   = (r_state == S_DIV) ? C_DIV_LAST : C_MULT_LAST;

    iter_counter #(
        .CW (CW)
    ) u_iter_counter (
        .clk     (clock),
        .rst     (reset),
        .clr     (w_start),
        .en      (w_cnt_en),
        .term    (w_term),
        .count   (iter_count),
        .at_term (w_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Op type and divide-by-zero are captured at start; multiply wins a tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op_div <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (w_start) begin
            r_op_div <= ~ctrl_MULT;
            r_dbz    <= ~ctrl_MULT & divisor_zero;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_MULT:  if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // A start in any state aborts and restarts.
        if (w_start) begin
            if (ctrl_MULT) begin
                w_next = S_MULT;
            end else if (divisor_zero) begin
                w_next = S_DONE;
            end else begin
                w_next = S_DIV;
            end
        end
    end

    always_comb begin
        dp_load        = w_start;
        dp_step        = 1'b0;
        booth_op       = BOOTH_NONE;
        div_sub        = 1'b0;
        div_fix        = 1'b0;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        case (r_state)
            S_MULT: begin
                dp_step  = 1'b1;
                busy     = 1'b1;
                booth_op = booth_decode(mult_bits);
            end
            S_DIV: begin
                dp_step = 1'b1;
                busy    = 1'b1;
                div_sub = (iter_count == '0) ? 1'b1 : ~rem_sign;
            end
            S_FIX: begin
                busy    = 1'b1;
                div_fix = rem_sign;
            end
            S_DONE: begin
                data_resultRDY = 1'b1;
                data_exception = r_dbz | (~r_op_div & mult_ovf);
            end
            default: begin
                dp_step = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire
